vdic_mult_seq: RTL

- Parametrised, iterative shift-add multiplier with per-argument parity checking and a req/ack/result_rdy handshake.
- Next generation of the team's 16x16 signed multiplier DUT. Adds:
  - generic operand width
  - a per-operation signed/unsigned mode
  - an explicit request-release rule
- Sits behind a requester that holds arguments stable while req is high.

---
 rtl/vdic_mult_pkg.sv | 18 +
 rtl/vdic_mult_shift_add.sv | 63 ++++++
 rtl/vdic_mult_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vdic_mult_pkg.sv
// Shared types and helpers for the vdic_mult_seq sequential shift-add multiplier.
package vdic_mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int unsigned PARITY_MAX_W = 64;

  // Even-parity reduce; narrower vectors are zero-extended by the caller.
  function automatic logic parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/vdic_mult_shift_add.sv
// Shift-add datapath: accumulator, multiplicand, multiplier shift registers and step counter.
module vdic_mult_shift_add #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DATA_W-1:0]     a_mag_i,
  input  logic [DATA_W-1:0]     b_mag_i,
  output logic [2*DATA_W-1:0]   acc_c_o,
  output logic                  zero_remaining_c_o,
  output logic                  last_c_o
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [RES_W-1:0]  acc_q, acc_d;
  logic [RES_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = RES_W'(a_mag_i);
      mplier_d = b_mag_i;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Accumulator including the bit processed on the coming edge.
  assign acc_c_o            = acc_d;
  assign zero_remaining_c_o = ((mplier_q >> 1) == '0);
  assign last_c_o           = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/vdic_mult_seq.sv
// Iterative signed/unsigned multiplier with argument parity check and req/ack/result_rdy handshake.
// Optional build macro VDIC_MULT_EARLY_EXIT_EN ends CALC once no multiplier bits remain.
module vdic_mult_seq
  import vdic_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                op_signed,
  input  logic [DATA_W-1:0]   arg_a,
  input  logic                arg_a_parity,
  input  logic [DATA_W-1:0]   arg_b,
  input  logic                arg_b_parity,
  output logic                ack,
  output logic [2*DATA_W-1:0] result,
  output logic                result_parity,
  output logic                result_rdy,
  output logic                arg_parity_error
);

  localparam int unsigned RES_W = 2 * DATA_W;

  state_t           state_q, state_d;
  logic             neg_q, neg_d;
  logic             ack_q, ack_d;
  logic             rdy_q, rdy_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             rpar_q, rpar_d;
  logic             perr_q, perr_d;

  logic              sign_a_c, sign_b_c, arg_err_c;
  logic [DATA_W-1:0] a_mag_c, b_mag_c;
  logic              load_c, step_c, calc_exit_c;
  logic [RES_W-1:0]  acc_c, prod_c;
  logic              zero_rem_c, last_c;

  // Operand conditioning: magnitudes for signed mode, pass-through otherwise.
  assign sign_a_c  = op_signed & arg_a[DATA_W-1];
  assign sign_b_c  = op_signed & arg_b[DATA_W-1];
  assign a_mag_c   = sign_a_c ? DATA_W'(-arg_a) : arg_a;
  assign b_mag_c   = sign_b_c ? DATA_W'(-arg_b) : arg_b;
  assign arg_err_c = (arg_a_parity != parity(PARITY_MAX_W'(arg_a)))
                   | (arg_b_parity != parity(PARITY_MAX_W'(arg_b)));
  assign prod_c    = neg_q ? -acc_c : acc_c;

  // zero_remaining is always set on the final step, so both forms agree there.
`ifdef VDIC_MULT_EARLY_EXIT_EN
  assign calc_exit_c = zero_rem_c | last_c;
`else
  assign calc_exit_c = zero_rem_c & last_c;
`endif

  vdic_mult_shift_add #(
    .DATA_W (DATA_W)
  ) u_shift_add (
    .clk                (clk),
    .rst                (rst),
    .load_i             (load_c),
    .step_i             (step_c),
    .a_mag_i            (a_mag_c),
    .b_mag_i            (b_mag_c),
    .acc_c_o            (acc_c),
    .zero_remaining_c_o (zero_rem_c),
    .last_c_o           (last_c)
  );

  always_comb begin
    state_d  = state_q;
    neg_d    = neg_q;
    ack_d    = 1'b0;
    rdy_d    = 1'b0;
    result_d = result_q;
    rpar_d   = rpar_q;
    perr_d   = perr_q;
    load_c   = 1'b0;
    step_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          load_c = 1'b1;
          ack_d  = 1'b1;
          neg_d  = sign_a_c ^ sign_b_c;
          if (arg_err_c) begin
            state_d  = DONE;
            rdy_d    = 1'b1;
            result_d = '0;
            rpar_d   = 1'b0;
            perr_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (calc_exit_c) begin
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = prod_c;
          rpar_d   = parity(PARITY_MAX_W'(prod_c));
          perr_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      neg_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      result_q <= '0;
      rpar_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      neg_q    <= neg_d;
      ack_q    <= ack_d;
      rdy_q    <= rdy_d;
      result_q <= result_d;
      rpar_q   <= rpar_d;
      perr_q   <= perr_d;
    end
  end

  assign ack              = ack_q;
  assign result_rdy       = rdy_q;
  assign result           = result_q;
  assign result_parity    = rpar_q;
  assign arg_parity_error = perr_q;

endmodule
